imm_encode: RTL and testbench

Instruction assembler, the inverse of the ID-stage immediate decode: takes a field-level description of an RV32I instruction (format select, 32-bit immediate, register and function fields) and emits the packed 32-bit instruction word. It also flags immediates that cannot be represented in the selected format. It sits on the debug/loader path feeding the IF instruction-injection port and the program-patch unit. It is a 2-stage valid/ready pipeline with full throughput and a saturating error counter.

---
 rtl/isa_pkg.sv | 36 +++
 rtl/imm_pack.sv | 65 ++++++
 rtl/imm_encode.sv | 104 ++++++++++
 tb/tb_imm_encode.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared RV32I encoding constants: immediate-format selects and major opcodes.
// Used by the instruction assembler and the ID-stage decoder.
package isa_pkg;

  // Immediate format selects; 3'b110 and 3'b111 are illegal.
  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;

  // RV32I major opcodes.
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Field-level description of one instruction, as captured by stage 1.
  typedef struct packed {
    logic [2:0]  imm_sel;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
  } req_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I instruction packer: places the immediate and the
// register/function fields into a 32-bit word and flags immediates that the
// selected format cannot represent.
module imm_pack
  import isa_pkg::*;
(
  input  logic [2:0]  imm_sel,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [6:0]  opcode,
  output logic [31:0] word,
  output logic        err
);

  // Sign-extension checks: the discarded upper bits must all equal the
  // format's top kept bit, otherwise the value is out of range.
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Format mux: pack the word and evaluate the range/alignment rule.
  // A legal format with a bad immediate still packs the truncated bits.
  always_comb begin
    word = '0;
    err  = 1'b0;
    case (imm_sel)
      IMM_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      IMM_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        err  = ~fits_12;
      end
      IMM_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = ~fits_12;
      end
      IMM_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = ~fits_13 | imm[0];
      end
      IMM_U: begin
        word = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      IMM_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = ~fits_21 | imm[0];
      end
      default: begin
        word = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encode.sv
// Two-stage instruction assembler pipeline. Stage 1 captures the request
// fields; the packer evaluates them; stage 2 holds the packed word and the
// error flag for the consumer. err_cnt saturates at 255.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer keeps valid and its payload steady until that edge;
// ready never depends on the same-side valid. Here in_ready depends only on
// pipeline occupancy and out_ready, and out_instr/out_err hold while
// out_valid && !out_ready.
module imm_encode
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_sel,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [6:0]  opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  req_t        s1_q;
  logic        s1_valid;
  logic        s1_advance;
  logic        s1_load;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;
  logic [31:0] pack_word;
  logic        pack_err;
  logic        out_fire;

  // Stage 1 moves on when stage 2 is empty or being drained this cycle.
  assign s1_advance = s1_valid && (!s2_valid || out_ready);
  assign in_ready   = !rst && (!s1_valid || s1_advance);
  assign s1_load    = in_valid && in_ready;
  assign out_fire   = s2_valid && out_ready;

  imm_pack u_pack (
    .imm_sel (s1_q.imm_sel),
    .imm     (s1_q.imm),
    .rd      (s1_q.rd),
    .rs1     (s1_q.rs1),
    .rs2     (s1_q.rs2),
    .funct3  (s1_q.funct3),
    .funct7  (s1_q.funct7),
    .opcode  (s1_q.opcode),
    .word    (pack_word),
    .err     (pack_err)
  );

  // Stage 1: capture an accepted request, or empty out when it advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_q     <= '{imm_sel: imm_sel, imm: imm, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7: funct7, opcode: opcode};
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: load the packed word from stage 1, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= 1'b1;
      s2_instr <= pack_word;
      s2_err   <= pack_err;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Count delivered error words, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_fire && s2_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_imm_encode.sv
// Directed bench for imm_encode: expected {err, word} pairs are queued when a
// request is accepted and compared when the consumer handshake occurs.
module tb_imm_encode;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int          checks = 0;
  int          errors = 0;
  int          model_cnt = 0;
  int          stall_left = 0;
  logic [32:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [32:0] hold_d = '0;

  imm_encode dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_sel   (imm_sel),
    .imm       (imm),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packing for I and S formats from the field table.
  function automatic logic [31:0] ref_i(input logic [31:0] v, input logic [4:0] a,
                                        input logic [2:0] f, input logic [4:0] d,
                                        input logic [6:0] op);
    return {v[11:0], a, f, d, op};
  endfunction

  function automatic logic [31:0] ref_s(input logic [31:0] v, input logic [4:0] b,
                                        input logic [4:0] a, input logic [2:0] f,
                                        input logic [6:0] op);
    return {v[11:5], b, a, f, v[4:0], op};
  endfunction

  // Consumer side of one cycle: stability while stalled, scoreboard pop.
  task automatic observe();
    logic [32:0] e;
    if (hold_v) begin
      chk("stall_valid", {32'd0, out_valid}, 33'd1);
      chk("stall_hold", {out_err, out_instr}, hold_d);
    end
    hold_v = out_valid && !out_ready;
    hold_d = {out_err, out_instr};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output: observed %h expected none", out_instr);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", {out_err, out_instr}, e);
        if (e[32] && model_cnt < 255) model_cnt++;
      end
    end
  endtask

  // One clock: set out_ready, settle, observe, then step past the edge.
  task automatic tick(output logic acc);
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
    #1;
    acc = in_valid && in_ready;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] sel, input logic [31:0] v,
                           input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op,
                           input logic [32:0] e);
    logic acc;
    logic done;
    imm_sel = sel; imm = v; rd = d; rs1 = a; rs2 = b;
    funct3 = f3; funct7 = f7; opcode = op;
    in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      tick(acc);
      if (acc) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed no accept expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(acc);
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] v;
    logic [4:0]  ra, rb, rdd;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    imm_sel = '0; imm = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_out_instr", {1'b0, out_instr}, 33'd0);
    chk("rst_out_err", {32'd0, out_err}, 33'd0);
    chk("rst_err_cnt", {25'd0, err_cnt}, 33'd0);
    chk("rst_in_ready", {32'd0, in_ready}, 33'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {32'd0, in_ready}, 33'd1);

    // I-type with two-edge latency check.
    drive_req(IMM_I, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, OP_IMM, {1'b0, 32'hFFF1_0093});
    chk("lat_edge1", {32'd0, out_valid}, 33'd0);
    tick(acc);
    chk("lat_edge2", {32'd0, out_valid}, 33'd1);
    drain();

    // B, J, U and their error forms.
    drive_req(IMM_B, 32'd8, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, OP_BRANCH, {1'b0, 32'h0020_8463});
    drive_req(IMM_B, 32'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, OP_BRANCH, {1'b1, 32'h0020_8163});
    drain();
    chk("b_err_cnt", {25'd0, err_cnt}, 33'd1);
    drive_req(IMM_J, 32'h0000_0800, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, OP_JAL, {1'b0, 32'h0010_00EF});
    drive_req(IMM_J, 32'h0010_0000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, OP_JAL, {1'b1, 32'h8000_00EF});
    drive_req(IMM_U, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, OP_LUI, {1'b0, 32'h1234_52B7});
    drive_req(IMM_U, 32'h1234_5001, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, OP_LUI, {1'b1, 32'h1234_52B7});
    // Range edges and illegal select.
    drive_req(IMM_I, 32'd2047, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, OP_IMM, {1'b0, 32'h7FF0_0013});
    drive_req(IMM_I, 32'd2048, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, OP_IMM, {1'b1, 32'h8000_0013});
    drive_req(3'b111, 32'h0000_0010, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, OP_OP, {1'b1, 32'h0});
    // R-type packs the raw fields.
    drive_req(IMM_R, 32'hDEAD_BEEF, 5'd3, 5'd4, 5'd5, 3'd7, 7'h20, OP_OP, {1'b0, 32'h4052_71B3});
    drain();
    chk("err_cnt_model", {25'd0, err_cnt}, 33'(model_cnt));

    // Random in-range I and S requests.
    for (int i = 0; i < 8; i++) begin
      v = 32'($signed($urandom_range(0, 4095)) - 2048);
      ra = 5'($urandom_range(0, 31)); rb = 5'($urandom_range(0, 31)); rdd = 5'($urandom_range(0, 31));
      if (i % 2 == 0)
        drive_req(IMM_I, v, rdd, ra, rb, 3'd2, 7'd0, OP_LOAD, {1'b0, ref_i(v, ra, 3'd2, rdd, OP_LOAD)});
      else
        drive_req(IMM_S, v, rdd, ra, rb, 3'd2, 7'd0, OP_STORE, {1'b0, ref_s(v, rb, ra, 3'd2, OP_STORE)});
    end
    drain();

    // Saturate the error counter.
    for (int i = 0; i < 300; i++)
      drive_req(3'b110, $urandom, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, OP_OP, {1'b1, 32'h0});
    drain();
    chk("err_cnt_sat", {25'd0, err_cnt}, 33'd255);

    // Backpressure: consumer stalls while four requests arrive.
    stall_left = 5;
    drive_req(IMM_I, 32'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, OP_IMM, {1'b0, ref_i(32'd1, 5'd0, 3'd0, 5'd1, OP_IMM)});
    drive_req(IMM_I, 32'd2, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, OP_IMM, {1'b0, ref_i(32'd2, 5'd0, 3'd0, 5'd2, OP_IMM)});
    chk("bp_in_ready_low", {32'd0, in_ready}, 33'd0);
    drive_req(IMM_I, 32'd3, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, OP_IMM, {1'b0, ref_i(32'd3, 5'd0, 3'd0, 5'd3, OP_IMM)});
    drive_req(IMM_I, 32'd4, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, OP_IMM, {1'b0, ref_i(32'd4, 5'd0, 3'd0, 5'd4, OP_IMM)});
    drain();

    // Reset with two error requests in flight: both must vanish.
    stall_left = 1000;
    drive_req(IMM_B, 32'd1, 5'd0, 5'd1, 5'd1, 3'd0, 7'd0, OP_BRANCH, {1'b1, 32'h0});
    drive_req(IMM_U, 32'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, OP_AUIPC, {1'b1, 32'h0});
    rst = 1'b1;
    exp_q.delete();
    hold_v = 1'b0;
    #1;
    chk("mid_rst_in_ready", {32'd0, in_ready}, 33'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("mid_rst_err_cnt", {25'd0, err_cnt}, 33'd0);
    model_cnt = 0;
    rst = 1'b0;
    stall_left = 0;
    #1;
    chk("mid_rst_in_ready_after", {32'd0, in_ready}, 33'd1);
    repeat (6) tick(acc);
    drive_req(IMM_S, 32'hFFFF_FFFC, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, OP_STORE, {1'b0, 32'hFE41_AE23});
    drain();
    chk("final_err_cnt", {25'd0, err_cnt}, 33'(model_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
